// File: rtl/divide_pkg.sv
// Shared execute-stage constants: M-extension func codes and divider FSM states.
package divide_pkg;

  localparam logic [3:0] OP_MUL    = 4'h0;
  localparam logic [3:0] OP_MULH   = 4'h1;
  localparam logic [3:0] OP_MULHSU = 4'h2;
  localparam logic [3:0] OP_MULHU  = 4'h3;
  localparam logic [3:0] OP_DIV    = 4'h4;
  localparam logic [3:0] OP_DIVU   = 4'h5;
  localparam logic [3:0] OP_REM    = 4'h6;
  localparam logic [3:0] OP_REMU   = 4'h7;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/divide_if.sv
// Issue and result handshake between the execute stage and the divider.
interface divide_if;
  logic        div_valid_i;
  logic [63:0] opr_a_i;
  logic [63:0] opr_b_i;
  logic [3:0]  div_func_i;
  logic        word_op_i;
  logic        div_ready_o;
  logic        div_ready_i;
  logic [63:0] div_res_o;
  logic        div_res_valid_o;
  logic        flush_i;

  modport master (
    output div_valid_i, opr_a_i, opr_b_i, div_func_i, word_op_i, div_ready_i, flush_i,
    input  div_ready_o, div_res_o, div_res_valid_o
  );

  modport slave (
    input  div_valid_i, opr_a_i, opr_b_i, div_func_i, word_op_i, div_ready_i, flush_i,
    output div_ready_o, div_res_o, div_res_valid_o
  );
endinterface

// File: rtl/divide.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
module divide
  import divide_pkg::*;
(
  input logic     clk,
  input logic     resetn,
  divide_if.slave dif
);

  div_state_t  state;
  logic [63:0] dvd, dvs, quot, result;
  logic [64:0] rem;
  logic [5:0]  cnt;
  logic        neg_q, neg_r, word_r;
  logic [3:0]  func_r;

  logic        signed_op, is_rem, sa, sb, b_zero, ovf;
  logic [31:0] a32, b32;
  logic [63:0] mag_a, mag_b, a_ext, spec_res;
  logic [64:0] trial, diff;
  logic        ge;
  logic [63:0] q_fix, r_fix, sel, fix_res;

  // Operand decode at the op width, plus the fast-path results.
  always_comb begin
    a32       = dif.opr_a_i[31:0];
    b32       = dif.opr_b_i[31:0];
    signed_op = (dif.div_func_i == OP_DIV) || (dif.div_func_i == OP_REM);
    is_rem    = (dif.div_func_i == OP_REM) || (dif.div_func_i == OP_REMU);
    sa        = signed_op & (dif.word_op_i ? a32[31] : dif.opr_a_i[63]);
    sb        = signed_op & (dif.word_op_i ? b32[31] : dif.opr_b_i[63]);
    if (dif.word_op_i) begin
      mag_a  = {32'b0, sa ? -a32 : a32};
      mag_b  = {32'b0, sb ? -b32 : b32};
      b_zero = (b32 == 32'b0);
      ovf    = signed_op && (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
      a_ext  = {{32{a32[31]}}, a32};
    end else begin
      mag_a  = sa ? -dif.opr_a_i : dif.opr_a_i;
      mag_b  = sb ? -dif.opr_b_i : dif.opr_b_i;
      b_zero = (dif.opr_b_i == 64'b0);
      ovf    = signed_op && (dif.opr_a_i == 64'h8000_0000_0000_0000) && (dif.opr_b_i == '1);
      a_ext  = dif.opr_a_i;
    end
    if (b_zero) spec_res = is_rem ? a_ext : '1;
    else        spec_res = is_rem ? 64'b0 : a_ext;
  end

  always_comb begin
    trial = {rem[63:0], dvd[63]};
    diff  = trial - {1'b0, dvs};
    ge    = (trial >= {1'b0, dvs});
  end

  // Sign fix-up; W results are sign-extended from bit 31.
  always_comb begin
    q_fix   = neg_q ? -quot : quot;
    r_fix   = neg_r ? -rem[63:0] : rem[63:0];
    sel     = ((func_r == OP_REM) || (func_r == OP_REMU)) ? r_fix : q_fix;
    fix_res = word_r ? {{32{sel[31]}}, sel[31:0]} : sel;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DIV_IDLE;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quot   <= '0;
      cnt    <= '0;
      result <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      func_r <= '0;
      word_r <= 1'b0;
    end else if (dif.flush_i && state != DIV_IDLE) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (dif.div_valid_i && !dif.flush_i) begin
          func_r <= dif.div_func_i;
          word_r <= dif.word_op_i;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          dvs    <= mag_b;
          dvd    <= dif.word_op_i ? {mag_a[31:0], 32'b0} : mag_a;
          rem    <= '0;
          quot   <= '0;
          cnt    <= dif.word_op_i ? 6'd31 : 6'd63;
          if (b_zero || ovf) begin
            result <= spec_res;
            state  <= DIV_DONE;
          end else begin
            state  <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          rem  <= ge ? diff : trial;
          dvd  <= {dvd[62:0], 1'b0};
          quot <= {quot[62:0], ge};
          if (cnt == 6'd0) state <= DIV_FIX;
          else             cnt   <= cnt - 6'd1;
        end
        DIV_FIX: begin
          result <= fix_res;
          state  <= DIV_DONE;
        end
        DIV_DONE: if (dif.div_ready_i) state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign dif.div_ready_o     = (state == DIV_IDLE);
  assign dif.div_res_valid_o = (state == DIV_DONE) && !dif.flush_i;
  assign dif.div_res_o       = (state == DIV_DONE) ? result : 64'b0;

endmodule

// File: tb/tb_divide.sv
// Randomized self-checking bench for divide against an arithmetic reference model.
module tb_divide;
  import divide_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  divide_if dif();

  divide u_dut (.clk(clk), .resetn(resetn), .dif(dif));

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic        exp_pending = 1'b0;
  logic [63:0] exp_res = '0;

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] f, input logic w);
    logic        s, r_op;
    logic [31:0] a32, b32, q32, r32, x32;
    logic [63:0] q, r;
    s    = (f == OP_DIV) || (f == OP_REM);
    r_op = (f == OP_REM) || (f == OP_REMU);
    a32  = a[31:0];
    b32  = b[31:0];
    if (w) begin
      if (b32 == 0)                                        begin q32 = '1;  r32 = a32; end
      else if (s && a32 == 32'h8000_0000 && b32 == '1)     begin q32 = a32; r32 = '0;  end
      else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else        begin q32 = a32 / b32; r32 = a32 % b32; end
      x32 = r_op ? r32 : q32;
      return {{32{x32[31]}}, x32};
    end
    if (b == 0)                                               begin q = '1; r = a;  end
    else if (s && a == 64'h8000_0000_0000_0000 && b == '1)    begin q = a;  r = '0; end
    else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else        begin q = a / b; r = a % b; end
    return r_op ? r : q;
  endfunction

  function automatic int latency(input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] f, input logic w);
    logic s;
    s = (f == OP_DIV) || (f == OP_REM);
    if (w && (b[31:0] == 0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == '1))) return 1;
    if (!w && (b == 0 || (s && a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
    return w ? 34 : 66;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Every cycle: a valid result must match the model; otherwise the bus reads 0.
  always @(negedge clk) begin
    if (dif.div_res_valid_o) begin
      tests++;
      if (!exp_pending || dif.div_res_o !== exp_res) begin
        fails++;
        $display("FAIL result: got %h valid=1 pending=%0d, expected %h", dif.div_res_o, exp_pending, exp_res);
      end
    end else if (!dif.flush_i) begin
      tests++;
      if (dif.div_res_o !== 64'b0) begin
        fails++;
        $display("FAIL res_idle: got %h, expected 0", dif.div_res_o);
      end
    end
  end

  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] f, input logic w);
    int g;
    g = 0;
    @(negedge clk);
    while (!dif.div_ready_o && g < 200) begin @(negedge clk); g++; end
    chk("ready_wait", {63'b0, dif.div_ready_o}, 64'd1);
    dif.div_valid_i = 1'b1;
    dif.opr_a_i     = a;
    dif.opr_b_i     = b;
    dif.div_func_i  = f;
    dif.word_op_i   = w;
    exp_res         = model(a, b, f, w);
    exp_pending     = 1'b1;
    @(posedge clk);
    #1 dif.div_valid_i = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] f, input logic w, input int hold);
    int          cyc;
    logic [63:0] held;
    start_op(a, b, f, w);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dif.div_res_valid_o && cyc < 200);
    chk("latency", 64'(cyc), 64'(latency(a, b, f, w)));
    held = dif.div_res_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", {62'b0, dif.div_res_valid_o, dif.div_ready_o}, 64'd2);
      chk("bp_stable", dif.div_res_o, held);
    end
    dif.div_ready_i = 1'b1;
    @(posedge clk);
    #1 exp_pending = 1'b0;
    dif.div_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_after", {62'b0, dif.div_ready_o, dif.div_res_valid_o}, 64'd2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    logic [3:0]  f;
    logic        w;
    dif.div_valid_i = 1'b0;
    dif.opr_a_i     = '0;
    dif.opr_b_i     = '0;
    dif.div_func_i  = OP_DIV;
    dif.word_op_i   = 1'b0;
    dif.div_ready_i = 1'b0;
    dif.flush_i     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {dif.div_res_o[61:0], dif.div_ready_o, dif.div_res_valid_o}, 64'd2);
    chk("reset_res", dif.div_res_o, 64'd0);
    resetn = 1'b1;

    // Hand-computed values that pin the model.
    chk("model_div",   model(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, OP_DIV, 1'b0), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_rem",   model(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, OP_REM, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_remu0", model(64'h1234, 64'd0, OP_REMU, 1'b0), 64'h1234);
    chk("model_ovf",   model(64'h8000_0000_0000_0000, '1, OP_DIV, 1'b0), 64'h8000_0000_0000_0000);
    chk("model_divuw", model(64'hFFFF_FFFE, 64'd2, OP_DIVU, 1'b1), 64'h0000_0000_7FFF_FFFF);
    chk("model_divw",  model(64'hFFFF_FFFE, 64'd2, OP_DIV, 1'b1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_divu",  model(64'd100, 64'd7, OP_DIVU, 1'b0), 64'd14);

    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, OP_DIV, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, OP_REM, 1'b0, 0);
    run_op(64'h1234, 64'd0, OP_DIVU, 1'b0, 0);
    run_op(64'h1234, 64'd0, OP_REMU, 1'b0, 0);
    run_op(64'd5, 64'd0, OP_DIV, 1'b1, 0);
    run_op(64'h8000_0000_0000_0000, '1, OP_DIV, 1'b0, 0);
    run_op(64'h8000_0000, 64'hFFFF_FFFF, OP_REM, 1'b1, 0);
    run_op(64'hFFFF_FFFE, 64'd2, OP_DIVU, 1'b1, 0);
    run_op(64'hFFFF_FFFE, 64'd2, OP_DIV, 1'b1, 0);
    run_op(64'd1000, 64'hFFFF_FFFF_FFFF_FFFD, OP_REM, 1'b0, 10);

    // Flush mid-run: nothing may come out, divider idles next cycle.
    start_op(64'h0123_4567_89AB_CDEF, 64'd3, OP_DIV, 1'b0);
    repeat (20) @(negedge clk);
    dif.flush_i = 1'b1;
    exp_pending = 1'b0;
    @(posedge clk);
    #1 dif.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'b0, dif.div_ready_o, dif.div_res_valid_o}, 64'd2);
    repeat (70) @(negedge clk);
    run_op(64'd100, 64'd7, OP_DIVU, 1'b0, 0);

    // Async reset mid-run: reset values at once, no stale result afterwards.
    start_op(64'hDEAD_BEEF_0000_1111, 64'd9, OP_REMU, 1'b0);
    repeat (30) @(negedge clk);
    resetn = 1'b0;
    exp_pending = 1'b0;
    #1;
    chk("rst_mid", {dif.div_res_o[61:0], dif.div_ready_o, dif.div_res_valid_o}, 64'd2);
    @(negedge clk);
    resetn = 1'b1;
    repeat (80) @(negedge clk);
    run_op(64'd77, 64'd10, OP_REM, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      int k;
      f = OP_DIV + 4'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      k = $urandom_range(0, 9);
      case (k)
        0: b = '0;
        1: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        2: b = 64'($urandom_range(1, 15));
        3: b = -64'($urandom_range(1, 15));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      if (k > 3 && b == 0) b = 64'd1;
      run_op(a, b, f, w, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divide.md
# divide

Iterative radix-2 integer divider for the execute stage, the inverse companion of the multiplier. It sits beside the multiplier behind the same valid/ready issue handshake and result handshake, with flush, and implements RV64M DIV, DIVU, REM, REMU and their W variants. Division is restoring and unsigned on operand magnitudes, followed by a sign fix-up. RISC-V divide-by-zero and overflow results are produced on a fast path.

## Interface
- No parameters. Operand width is fixed at 64; word ops use bits [31:0].
- Reset is `resetn`, asynchronous, active-low. The clock is `clk`.
- `clk`  in  1  clock
- `resetn`  in  1  async active-low reset
- `div_valid_i`  in  1  operation offered
- `opr_a_i`  in  64  dividend
- `opr_b_i`  in  64  divisor
- `div_func_i`  in  4  OP_DIV / OP_DIVU / OP_REM / OP_REMU
- `word_op_i`  in  1  32-bit W variant
- `div_ready_o`  out  1  can accept; high only in DIV_IDLE
- `div_ready_i`  in  1  consumer accepts result
- `div_res_o`  out  64  result; 0 outside DIV_DONE
- `div_res_valid_o`  out  1  result valid; `~flush_i` while in DIV_DONE
- `flush_i`  in  1  pipeline flush; abort the current op

## Operation
- States: DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE.
- Reset values:
  - state = DIV_IDLE; all registers 0.
  - `div_ready_o` = 1, `div_res_valid_o` = 0, `div_res_o` = 0.
- Signedness:
  - `signed_op` = (func == OP_DIV | OP_REM).
  - Sign bits are bit 63 for doubleword ops and bit 31 for word ops.
  - Unsigned ops treat the sign bits as 0.
- Magnitudes: if the sign bit is set, take the two's complement of the operand at the op width; otherwise the operand is zero-extended at the op width.
- Latched in DIV_IDLE on `div_valid_i & ~flush_i`:
  - dividend and divisor magnitudes, func, word_op;
  - `neg_q` = sa ^ sb; `neg_r` = sa.
- Special cases, decided in DIV_IDLE at the op width:
  - Divisor zero:
    - quotient = all ones;
    - remainder = dividend, raw operand bits.
  - Signed overflow (dividend = most-negative, divisor = all ones):
    - quotient = dividend;
    - remainder = 0.
  - Either case loads the result register directly and goes DIV_IDLE -> DIV_DONE.
- Otherwise go to DIV_RUN with the iteration counter = 63, or 31 for word ops.
  - For word ops the dividend magnitude is pre-shifted left by 32 in the shift register.
- DIV_RUN, one quotient bit per cycle:
  - trial = {rem[63:0], dvd[63]} (65 bits);
  - if trial >= {1'b0, divisor}: rem = trial − divisor and qbit = 1; else rem = trial and qbit = 0;
  - shift dvd left 1; shift qbit into the quotient LSB;
  - leave for DIV_FIX when the counter reaches 0, otherwise decrement.
- DIV_FIX, one cycle:
  - q = `neg_q` ? −quot : quot;
  - r = `neg_r` ? −rem : rem;
  - select q (DIV/DIVU) or r (REM/REMU);
  - for word ops, sign-extend bit 31 into [63:32];
  - register the result; go to DIV_DONE.
- DIV_DONE:
  - `div_res_o` = result register;
  - valid = `~flush_i`;
  - on `div_ready_i | flush_i`, go to DIV_IDLE.
- Flush in DIV_RUN, DIV_FIX or DIV_DONE: next state DIV_IDLE; no valid is asserted in the flush cycle; partial state is discarded.
- Flush in DIV_IDLE blocks acceptance.

## Timing
- Accept edge = edge E, in DIV_IDLE.
- Doubleword normal op:
  - 64 DIV_RUN cycles + 1 DIV_FIX cycle;
  - valid first asserted in the cycle after edge E+65.
- Word normal op: valid first asserted in the cycle after edge E+33.
- Special case: valid in the cycle immediately after edge E.
- Back-to-back: valid & ready in DIV_DONE returns to DIV_IDLE at the next edge, where the next op may be accepted. Throughput is at most one op per latency + 1 cycles.
- `div_res_o` is stable while valid is held under backpressure.
- Async reset mid-operation: immediate return to reset values; no stale result later.

## Structure
- Shared package additions:
  - OP_DIV, OP_DIVU, OP_REM, OP_REMU in `cpu_consts`, 4-bit, distinct from the OP_MUL* codes;
  - `div_state_t` (DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE) in `cpu_modules`. Its literals are distinct from `mul_state_t`.
- Single module `divide`; no sub-module. The restoring step is plain combinational logic inside it.
- Registers:
  - 64-bit dividend shift register, 64-bit divisor, 65-bit remainder, 64-bit quotient;
  - 6-bit counter, 64-bit result;
  - `neg_q`, `neg_r`, func, word_op.

## Test plan
- DIV signed doubleword:
  - a = 0xFFFF_FFFF_FFFF_FFF9 (−7), b = 2 -> 0xFFFF_FFFF_FFFF_FFFD, valid exactly 66 cycles after accept;
  - REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- Divide by zero:
  - DIVU a = 0x1234, b = 0 -> 0xFFFF_FFFF_FFFF_FFFF, valid 1 cycle after accept;
  - REMU -> 0x1234;
  - DIVW a = 5, b = 0 -> 0xFFFF_FFFF_FFFF_FFFF.
- Overflow:
  - DIV a = 0x8000_0000_0000_0000, b = 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000;
  - REMW a = 0x8000_0000, b = 0xFFFF_FFFF -> 0.
- Word ops:
  - DIVUW a = 0xFFFF_FFFE, b = 2 -> 0x0000_0000_7FFF_FFFF;
  - DIVW a = 0xFFFF_FFFE, b = 2 -> 0xFFFF_FFFF_FFFF_FFFF, valid 34 cycles after accept.
- Backpressure:
  - hold `div_ready_i` = 0 for 10 cycles in DIV_DONE -> valid high, result stable, `div_ready_o` = 0 throughout;
  - raise `div_ready_i` -> DIV_IDLE next cycle.
- Flush and reset:
  - flush at RUN cycle 20 -> no valid, `div_ready_o` = 1 next cycle;
  - a following DIVU 100/7 -> 14;
  - resetn low mid-RUN -> outputs at reset values, no spurious valid.
